// File: rtl/alignment_scheduler_pkg.sv
// Shared types and constants for the temporal-alignment epoch sequencer.
package alignment_pkg;

  localparam int unsigned NUM_SENSORS = 4;

  localparam int unsigned SENS_LIDAR  = 0;
  localparam int unsigned SENS_CAMERA = 1;
  localparam int unsigned SENS_RADAR  = 2;
  localparam int unsigned SENS_IMU    = 3;

  localparam int unsigned DEF_MIN_COUNT      = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_MATCH,
    ST_PICK,
    ST_WAIT_INTERP,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/alignment_scheduler_watchdog.sv
// Shared watchdog for the two wait states: loads on clear, counts down while
// enabled, and flags timeout once TIMEOUT_CYCLES-1 enabled cycles have elapsed.
module align_watchdog
  import alignment_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_remain;

  // Remaining reaching zero is the same instant as elapsed == TIMEOUT_CYCLES-1.
  assign o_timeout = i_en && (r_remain == '0);

  // Reload on state entry, otherwise count down while a wait state is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remain <= '0;
    end else if (i_clr) begin
      r_remain <= LAST;
    end else if (i_en && !o_timeout) begin
      r_remain <= r_remain - 1'b1;
    end
  end

endmodule

// File: rtl/alignment_scheduler.sv
// Epoch sequencer: starts eligible matchers on sync, collects completions,
// steps the shared interpolator through ok sensors, then closes the frame.
module alignment_scheduler
  import alignment_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = alignment_pkg::NUM_SENSORS,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned MIN_COUNT      = DEF_MIN_COUNT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync_signal,
  input  logic [NUM_SENSORS*CNT_W-1:0] fifo_count,
  output logic [NUM_SENSORS-1:0]       match_start,
  input  logic [NUM_SENSORS-1:0]       match_done,
  input  logic [NUM_SENSORS-1:0]       match_error,
  output logic                         interp_start,
  output logic [1:0]                   interp_sel,
  input  logic                         interp_valid,
  input  logic                         interp_error,
  output logic [NUM_SENSORS-1:0]       latch_en,
  output logic                         frame_valid,
  output logic [NUM_SENSORS-1:0]       frame_mask,
  output logic                         error,
  output logic                         busy,
  output logic [7:0]                   overrun_count,
  output logic [15:0]                  epoch_count
);

  localparam logic [CNT_W-1:0]       MIN_CNT = CNT_W'(MIN_COUNT);
  localparam logic [NUM_SENSORS-1:0] ONE_1H  = {{(NUM_SENSORS-1){1'b0}}, 1'b1};

  state_t r_state, w_next;

  logic [NUM_SENSORS-1:0] r_elig, r_done, r_ok, r_served, r_mask;
  logic [NUM_SENSORS-1:0] w_elig_now, w_hit, w_cand, w_sel_1h;
  logic [NUM_SENSORS-1:0] r_match_start, r_latch_en, r_frame_mask;
  logic [1:0]             r_sel, w_pick_idx;
  logic                   w_found, w_timeout, w_int_fail, w_overrun, w_err_ev;
  logic                   r_interp_start, r_frame_valid, r_error, r_busy;
  logic [7:0]             r_overrun;
  logic [15:0]            r_epoch;

  assign w_hit      = (r_state == ST_WAIT_MATCH) ? (match_done & r_elig & ~r_done) : '0;
  assign w_cand     = r_ok & ~r_served;
  assign w_found    = |w_cand;
  assign w_sel_1h   = ONE_1H << r_sel;
  assign w_int_fail = (r_state == ST_WAIT_INTERP) && (interp_error || w_timeout);
  assign w_overrun  = sync_signal && (r_state != ST_IDLE);

  align_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_next != r_state),
    .i_en     ((r_state == ST_WAIT_MATCH) || (r_state == ST_WAIT_INTERP)),
    .o_timeout(w_timeout)
  );

  // Eligibility: a sensor needs a bracketing pair in its FIFO.
  always_comb begin
    w_elig_now = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      w_elig_now[i] = (fifo_count[i*CNT_W +: CNT_W] >= MIN_CNT);
    end
  end

  // Lowest-index ok sensor not yet interpolated.
  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = NUM_SENSORS; i > 0; i--) begin
      if (w_cand[i-1]) w_pick_idx = 2'(i - 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and error-event decode.
  always_comb begin
    w_next   = r_state;
    w_err_ev = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (sync_signal) w_next = ST_START;
      ST_START: w_next = (r_elig == '0) ? ST_EMIT : ST_WAIT_MATCH;
      ST_WAIT_MATCH: begin
        if (|(w_hit & match_error)) w_err_ev = 1'b1;
        if ((r_done | w_hit) == r_elig) begin
          w_next = ST_PICK;
        end else if (w_timeout) begin
          w_next   = ST_PICK;
          w_err_ev = 1'b1;
        end
      end
      ST_PICK: w_next = w_found ? ST_WAIT_INTERP : ST_EMIT;
      ST_WAIT_INTERP: begin
        if (w_int_fail) begin
          w_next   = ST_PICK;
          w_err_ev = 1'b1;
        end else if (interp_valid) begin
          w_next = ST_PICK;
        end
      end
      ST_EMIT: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_overrun) w_err_ev = 1'b1;
  end

  // Per-epoch bookkeeping. Cleared on sync acceptance so that an empty epoch
  // already sees a zero mask when it enters EMIT straight from START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elig   <= '0;
      r_done   <= '0;
      r_ok     <= '0;
      r_served <= '0;
      r_mask   <= '0;
      r_sel    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (sync_signal) begin
          r_elig   <= w_elig_now;
          r_done   <= '0;
          r_ok     <= '0;
          r_served <= '0;
          r_mask   <= '0;
        end
        ST_WAIT_MATCH: begin
          r_done <= r_done | w_hit;
          r_ok   <= r_ok | (w_hit & ~match_error);
        end
        ST_PICK: if (w_found) r_sel <= w_pick_idx;
        ST_WAIT_INTERP: begin
          if (w_int_fail) begin
            r_served <= r_served | w_sel_1h;
            r_mask   <= r_mask & ~w_sel_1h;
          end else if (interp_valid) begin
            r_served <= r_served | w_sel_1h;
            r_mask   <= r_mask | w_sel_1h;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and counters, timed to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_start  <= '0;
      r_interp_start <= 1'b0;
      r_latch_en     <= '0;
      r_frame_valid  <= 1'b0;
      r_frame_mask   <= '0;
      r_error        <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= '0;
      r_epoch        <= '0;
    end else begin
      r_match_start  <= ((r_state == ST_IDLE) && sync_signal) ? w_elig_now : '0;
      r_interp_start <= (r_state == ST_PICK) && w_found;
      r_latch_en     <= ((r_state == ST_WAIT_INTERP) && interp_valid && !w_int_fail) ? w_sel_1h : '0;
      r_frame_valid  <= (w_next == ST_EMIT);
      r_error        <= w_err_ev;
      r_busy         <= (w_next != ST_IDLE) && (w_next != ST_EMIT);
      if (w_next == ST_EMIT) begin
        r_frame_mask <= r_mask;
        r_epoch      <= r_epoch + 1'b1;
      end
      if (w_overrun && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 1'b1;
    end
  end

  assign match_start   = r_match_start;
  assign interp_start  = r_interp_start;
  assign interp_sel    = r_sel;
  assign latch_en      = r_latch_en;
  assign frame_valid   = r_frame_valid;
  assign frame_mask    = r_frame_mask;
  assign error         = r_error;
  assign busy          = r_busy;
  assign overrun_count = r_overrun;
  assign epoch_count   = r_epoch;

endmodule

// File: tb/tb_alignment_scheduler.sv
// Self-checking bench for alignment_scheduler with a behavioural epoch model.
module tb_alignment_scheduler;

  localparam int TO    = 16;
  localparam int MINC  = 2;
  localparam int NEVER = -1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_signal = 1'b0;
  logic [15:0] fifo_count = '0;
  logic [3:0]  match_start, match_done = '0, match_error = '0;
  logic        interp_start, interp_valid = 1'b0, interp_error = 1'b0;
  logic [1:0]  interp_sel;
  logic [3:0]  latch_en, frame_mask;
  logic        frame_valid, error, busy;
  logic [7:0]  overrun_count;
  logic [15:0] epoch_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_epoch = 0;
  int exp_overrun = 0;
  int first_err_cyc;

  int cfg_cnt[4];
  int cfg_dly[4];
  int cfg_idly[4];
  bit cfg_merr[4];
  bit cfg_ierr[4];
  bit cfg_both[4];
  int cfg_ovr;

  alignment_scheduler #(
    .NUM_SENSORS   (4),
    .CNT_W         (4),
    .MIN_COUNT     (MINC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_signal  (sync_signal),
    .fifo_count   (fifo_count),
    .match_start  (match_start),
    .match_done   (match_done),
    .match_error  (match_error),
    .interp_start (interp_start),
    .interp_sel   (interp_sel),
    .interp_valid (interp_valid),
    .interp_error (interp_error),
    .latch_en     (latch_en),
    .frame_valid  (frame_valid),
    .frame_mask   (frame_mask),
    .error        (error),
    .busy         (busy),
    .overrun_count(overrun_count),
    .epoch_count  (epoch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cfg_default();
    for (int i = 0; i < 4; i++) begin
      cfg_cnt[i] = 4; cfg_idly[i] = 2;
      cfg_merr[i] = 0; cfg_ierr[i] = 0; cfg_both[i] = 0;
    end
    cfg_dly[0] = 3; cfg_dly[1] = 5; cfg_dly[2] = 4; cfg_dly[3] = 6;
    cfg_ovr = -1;
  endtask

  // Runs one epoch from sync to frame close against the epoch model.
  task automatic run_epoch(input string name);
    logic [3:0] elig, okv, expm, lacc;
    int done_cyc[4];
    int order[$];
    bit errcyc[64];
    int dmax, exp_err, seen_err, prev, n_st, cur, resp, latches, extra_frames, c, s;
    bit any_never, got_frame;
    elig = '0; okv = '0; expm = '0; lacc = '0;
    dmax = 0; exp_err = 0; any_never = 0;
    for (int k = 0; k < 64; k++) errcyc[k] = 0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = (cfg_cnt[i] >= MINC);
      done_cyc[i] = (cfg_dly[i] == NEVER) ? -1 : 1 + cfg_dly[i];
      if (elig[i]) begin
        if (done_cyc[i] < 0) any_never = 1;
        else begin
          if (done_cyc[i] > dmax) dmax = done_cyc[i];
          if (cfg_merr[i]) errcyc[done_cyc[i]] = 1;
          else okv[i] = 1;
        end
      end
    end
    for (int k = 0; k < 64; k++) if (errcyc[k]) exp_err++;
    if (any_never) begin exp_err++; dmax = TO + 1; end
    for (int i = 0; i < 4; i++) if (okv[i]) begin
      order.push_back(i);
      if (cfg_ierr[i]) exp_err++; else expm[i] = 1'b1;
    end
    if (cfg_ovr > 0) begin
      exp_err++;
      if (exp_overrun < 255) exp_overrun++;
    end
    prev = (elig == '0) ? 0 : dmax;

    seen_err = 0; n_st = 0; cur = 0; resp = -1; latches = 0; got_frame = 0;
    first_err_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) fifo_count[i*4 +: 4] = 4'(cfg_cnt[i]);
    sync_signal = 1'b1;
    for (c = 1; c <= 200 && !got_frame; c++) begin
      @(negedge clk);
      sync_signal = 0; match_done = '0; match_error = '0; interp_valid = 0; interp_error = 0;
      if (c == 1) begin
        n_checks++;
        if (match_start !== elig) begin n_errors++;
          $display("FAIL %s match_start got %b exp %b", name, match_start, elig); end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy_on got %b exp 1", name, busy); end
      end
      if (c == 2) begin
        n_checks++;
        if (match_start !== 4'b0) begin n_errors++;
          $display("FAIL %s match_start_width got %b exp 0000", name, match_start); end
      end
      if (error === 1'b1) begin
        seen_err++;
        if (first_err_cyc < 0) first_err_cyc = c;
      end
      if (latch_en !== 4'b0) begin latches++; lacc |= latch_en; end
      if (resp >= 0 && c == resp + 1) begin
        n_checks++;
        if (latch_en !== (expm[order[cur]] ? (4'b0001 << order[cur]) : 4'b0000)) begin n_errors++;
          $display("FAIL %s latch_en c=%0d got %b sensor %0d", name, c, latch_en, order[cur]); end
      end
      if (interp_start === 1'b1) begin
        n_checks++;
        if (n_st >= order.size()) begin n_errors++;
          $display("FAIL %s extra_interp_start c=%0d got sel %0d exp none", name, c, interp_sel);
        end else begin
          if (c != prev + 2 || interp_sel !== 2'(order[n_st])) begin n_errors++;
            $display("FAIL %s interp_start c=%0d sel %0d exp c=%0d sel %0d",
                     name, c, interp_sel, prev + 2, order[n_st]); end
          cur = n_st; resp = c + cfg_idly[order[cur]]; n_st++;
        end
      end
      if (frame_valid === 1'b1) begin
        got_frame = 1;
        n_checks++;
        if (c != prev + 2 || frame_mask !== expm || busy !== 1'b0 || epoch_count !== 16'(exp_epoch + 1)) begin
          n_errors++;
          $display("FAIL %s frame c=%0d mask %b busy %b epoch %0d exp c=%0d mask %b busy 0 epoch %0d",
                   name, c, frame_mask, busy, epoch_count, prev + 2, expm, exp_epoch + 1);
        end
      end
      for (int i = 0; i < 4; i++) if (c == done_cyc[i]) begin
        match_done[i] = 1'b1; match_error[i] = cfg_merr[i];
      end
      if (c == resp) begin
        s = order[cur];
        n_checks++;
        if (interp_sel !== 2'(s)) begin n_errors++;
          $display("FAIL %s interp_sel_hold got %0d exp %0d", name, interp_sel, s); end
        if (cfg_ierr[s]) begin interp_error = 1; interp_valid = cfg_both[s]; end
        else interp_valid = 1;
        prev = c;
      end
      if (c == cfg_ovr) sync_signal = 1'b1;
    end
    exp_epoch++;
    n_checks++;
    if (!got_frame) begin n_errors++;
      $display("FAIL %s frame_timeout got none exp frame_valid within 200 cycles", name); end
    extra_frames = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) extra_frames++;
      if (error === 1'b1) seen_err++;
    end
    n_checks++;
    if (extra_frames != 0) begin n_errors++;
      $display("FAIL %s extra_frame got %0d exp 0", name, extra_frames); end
    n_checks++;
    if (seen_err != exp_err) begin n_errors++;
      $display("FAIL %s error_cycles got %0d exp %0d", name, seen_err, exp_err); end
    n_checks++;
    if (lacc !== expm || latches != $countones(expm) || n_st != order.size()) begin n_errors++;
      $display("FAIL %s latches got %b/%0d starts %0d exp %b/%0d starts %0d",
               name, lacc, latches, n_st, expm, $countones(expm), order.size()); end
    n_checks++;
    if (overrun_count !== 8'(exp_overrun) || epoch_count !== 16'(exp_epoch)) begin n_errors++;
      $display("FAIL %s counters got ovr %0d epoch %0d exp ovr %0d epoch %0d",
               name, overrun_count, epoch_count, exp_overrun, exp_epoch); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({match_start, interp_start, interp_sel, latch_en, frame_valid, frame_mask,
         error, busy, overrun_count, epoch_count} !== '0) begin n_errors++;
      $display("FAIL reset_state got nonzero outputs exp all 0"); end
    rst_n = 1'b1;
  endtask

  task automatic test_all_eligible();
    cfg_default();
    run_epoch("all_eligible");
  endtask

  task automatic test_ineligible();
    cfg_default();
    cfg_cnt[1] = 1; cfg_cnt[2] = 0;
    run_epoch("ineligible");
  endtask

  task automatic test_matcher_error();
    cfg_default();
    cfg_merr[0] = 1;
    run_epoch("matcher_error");
  endtask

  task automatic test_watchdog();
    cfg_default();
    cfg_dly[3] = NEVER;
    run_epoch("watchdog");
    n_checks++;
    if (first_err_cyc != TO + 2) begin n_errors++;
      $display("FAIL watchdog_timing got error at %0d exp %0d", first_err_cyc, TO + 2); end
  endtask

  task automatic test_overrun();
    cfg_default();
    cfg_ovr = 3;
    run_epoch("overrun");
  endtask

  task automatic test_interp_error();
    cfg_default();
    cfg_ierr[2] = 1; cfg_both[2] = 1; cfg_idly[1] = 0; cfg_idly[3] = 3;
    run_epoch("interp_error");
  endtask

  task automatic test_empty_epoch();
    cfg_default();
    for (int i = 0; i < 4; i++) cfg_cnt[i] = $urandom_range(0, 1);
    run_epoch("empty_epoch");
  endtask

  task automatic test_random(input int n);
    for (int e = 0; e < n; e++) begin
      cfg_default();
      for (int i = 0; i < 4; i++) begin
        cfg_cnt[i]  = $urandom_range(0, 5);
        cfg_dly[i]  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 8));
        cfg_merr[i] = ($urandom_range(0, 5) == 0);
        cfg_idly[i] = $urandom_range(0, 3);
        cfg_ierr[i] = ($urandom_range(0, 4) == 0);
        cfg_both[i] = $urandom_range(0, 1);
      end
      run_epoch($sformatf("random_%0d", e));
    end
  endtask

  task automatic test_reset_mid_epoch();
    bit hit;
    cfg_default();
    @(negedge clk);
    fifo_count = 16'h4444; sync_signal = 1'b1;
    hit = 0;
    for (int c = 1; c <= 40 && !hit; c++) begin
      @(negedge clk);
      sync_signal = 0; match_done = '0; match_error = '0;
      if (c == 3) match_done = 4'hF;
      if (interp_start === 1'b1) hit = 1;
    end
    n_checks++;
    if (!hit) begin n_errors++; $display("FAIL reset_mid_setup got no interp_start exp one"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({match_start, interp_start, interp_sel, latch_en, frame_valid, frame_mask,
         error, busy, overrun_count, epoch_count} !== '0) begin n_errors++;
      $display("FAIL reset_mid_outputs got frame_mask %b epoch %0d busy %b exp all 0",
               frame_mask, epoch_count, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_epoch = 0; exp_overrun = 0;
    run_epoch("after_reset");
  endtask

  initial begin
    test_reset();
    test_all_eligible();
    test_ineligible();
    test_matcher_error();
    test_watchdog();
    test_overrun();
    test_interp_error();
    test_empty_epoch();
    test_random(10);
    test_reset_mid_epoch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alignment_scheduler.md
# alignment_scheduler

Epoch sequencer for the temporal-alignment path. It sits between the sync source, the per-sensor FIFO/matcher units and one time-shared interpolation engine. On each sync pulse it starts the eligible matchers, collects their completions with a timeout, then steps the shared interpolator through the matched sensors in index order. It closes the epoch with a one-cycle frame strobe and a per-sensor validity mask for the data assembler.

## Interface
- NUM_SENSORS, 4, sensor channels (index 0 lidar, 1 camera, 2 radar, 3 imu)
- CNT_W, 4, width of each FIFO occupancy field
- MIN_COUNT, 2, minimum FIFO occupancy for a sensor to be eligible (bracketing pair)
- TIMEOUT_CYCLES, 1024, watchdog limit for the WAIT_MATCH and WAIT_INTERP states
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sync_signal  in  1  epoch trigger, single-cycle pulse
- fifo_count  in  NUM_SENSORS*CNT_W  per-sensor occupancy, sensor i at [i*CNT_W +: CNT_W]
- match_start  out  NUM_SENSORS  one-cycle start pulse per matcher
- match_done  in  NUM_SENSORS  matcher completion pulses
- match_error  in  NUM_SENSORS  matcher error, sampled with done
- interp_start  out  1  one-cycle start to the shared interpolator
- interp_sel  out  2  sensor index steering the interpolator packet mux
- interp_valid  in  1  interpolator result ready
- interp_error  in  1  interpolator failure
- latch_en  out  NUM_SENSORS  one-cycle capture strobe into the assembler slot of sensor i
- frame_valid  out  1  one-cycle end-of-epoch strobe
- frame_mask  out  NUM_SENSORS  sensors with valid data this epoch, held until the next frame_valid
- error  out  1  one-cycle pulse on any matcher/interp error, timeout or overrun
- busy  out  1  high from the cycle after an accepted sync until frame_valid
- overrun_count  out  8  syncs dropped while busy, saturating
- epoch_count  out  16  completed epochs, wraps

## Operation
- States: IDLE, START, WAIT_MATCH, PICK, WAIT_INTERP, EMIT.
- IDLE:
  - On sync_signal, go to START.
  - Latch elig[i] = (fifo_count[i] >= MIN_COUNT).
- START:
  - match_start = elig for one cycle.
  - Clear pend_done; clear the watchdog.
  - If elig == 0, go straight to EMIT.
  - Otherwise go to WAIT_MATCH.
- WAIT_MATCH:
  - Each match_done[i] with elig[i] sets done_r[i] and ok[i] = !match_error[i].
  - match_error with done raises error.
  - done pulses from non-eligible sensors are ignored.
  - Exit to PICK when done_r == elig, or on timeout.
  - On timeout: pulse error; sensors not yet done are treated as not ok.
- PICK:
  - Select the lowest index i with ok[i] and not yet interpolated.
  - Drive interp_sel = i, pulse interp_start, go to WAIT_INTERP.
  - If no such sensor remains, go to EMIT.
- WAIT_INTERP:
  - On interp_valid && !interp_error: latch_en[sel] pulses; mask[sel] = 1.
  - On interp_error: error pulses; mask[sel] = 0.
  - Either event marks sel as served and returns to PICK.
  - Timeout behaves as interp_error.
  - interp_sel holds stable for the whole state.
- EMIT:
  - frame_valid = 1 for one cycle; frame_mask <= mask.
  - epoch_count increments; return to IDLE.
- sync_signal in any state other than IDLE:
  - The sync is dropped; error pulses; overrun_count increments, saturating at 255.
  - A sync in the EMIT cycle also counts as an overrun.
- Watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits. It resets on each state entry. Timeout fires when count == TIMEOUT_CYCLES-1.
- Simultaneous events in WAIT_INTERP: interp_valid and interp_error together resolve as error.
- interp_error outside WAIT_INTERP is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; frame_mask 0.
- Output registration:
  - All outputs are registered.
  - Exception: interp_sel is a direct register, stable from the interp_start cycle.
- Sync accepted at cycle T: match_start asserts at T+1; busy asserts at T+1.
- Match completion:
  - Last required match_done at cycle D gives interp_start at D+2, since PICK takes one cycle.
- Interpolation completion:
  - interp_valid at cycle V gives latch_en at V+1.
  - The next interp_start follows at V+2.
- Frame close:
  - After the last interpolation, frame_valid asserts two cycles after the final interp_valid.
  - busy deasserts in the same cycle as frame_valid.
- Empty epoch (no eligible sensors): frame_valid at T+2 with mask 0.
- rst_n asserted mid-epoch:
  - Immediate return to IDLE; no frame_valid.
  - Counters and frame_mask clear.

## Structure
- Package alignment_pkg holds:
  - the state enum;
  - the sensor index constants (SENS_LIDAR=0, SENS_CAMERA=1, SENS_RADAR=2, SENS_IMU=3);
  - NUM_SENSORS;
  - the default MIN_COUNT and TIMEOUT_CYCLES.
- Sub-module align_watchdog: parameterised down-counter with clear and a timeout pulse. It is instantiated once and shared by both WAIT states.
- The lowest-index priority pick stays inline.

## Test plan
- **All four eligible:**
  - Stimulus: fifo_count=4 each; sync; matcher dones at +3/+5/+4/+6; interp_valid 2 cycles after each start.
  - Expected: interp_sel sequence 0,1,2,3; four latch_en pulses; frame_valid with mask 4'b1111; epoch_count=1.
- **Ineligible sensors:**
  - Stimulus: camera count=1, radar count=0.
  - Expected: match_start=4'b1001; only sensors 0 and 3 interpolated; mask 4'b1001.
- **Matcher error:**
  - Stimulus: lidar match_error with done.
  - Expected: error pulses one cycle; lidar skipped; mask 4'b1110.
- **Watchdog:**
  - Stimulus: TIMEOUT_CYCLES=16; imu never completes.
  - Expected: error pulses 16 cycles after WAIT_MATCH entry; mask 4'b0111.
- **Overrun:**
  - Stimulus: second sync 3 cycles after the first.
  - Expected: overrun_count=1; error pulses; exactly one frame_valid.
- **Reset mid-epoch:**
  - Stimulus: rst_n low during WAIT_INTERP.
  - Expected: all outputs 0.
  - Follow-up: the next sync completes a normal epoch with epoch_count=1.
